led_cube_scan_driver: RTL and testbench

- Parametrised next-generation cube driver for an N×N×N LED cube with a native double-buffered frame store and layer-multiplexed scan engine.
- Decodes command bytes from the UART byte stream: mode set, brightness set, and frame upload.
- Mode changes take effect only on layer boundaries, so a layer is never torn mid-dwell.
- Sits between the UART receiver and the cube's layer/latch/data pins.

---
 rtl/led_cube_scan_driver.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_led_cube_scan_driver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_cube_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_cube_scan_driver
//  Description : Drives an N x N x N LED cube from a UART byte stream.
//                Decodes mode, brightness and frame-upload commands. Frames
//                are held in a double-buffered store. A layer-multiplexed
//                scan engine latches each layer's rows and then drives the
//                layer for a brightness-scaled share of its dwell period.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_cube_scan_driver #(
    parameter int CUBE_N = 8,   // cube side length (2..8)
    parameter int DWELL  = 64,  // cycles per layer dwell phase (>= 16)
    parameter int CNT_W  = 8    // dwell counter width, must hold DWELL-1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        uart_in,
    input  logic              readdatavalid,
    output logic [CUBE_N-1:0] layers_out,
    output logic [CUBE_N-1:0] latches_out,
    output logic [CUBE_N-1:0] data_out,
    output logic [3:0]        mode,
    output logic              frame_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_CELLS = CUBE_N * CUBE_N;
    localparam int C_IDX_W = $clog2(C_CELLS);
    localparam int C_POS_W = $clog2(CUBE_N);

    localparam logic [C_IDX_W-1:0] C_IDX_LAST   = C_IDX_W'(C_CELLS - 1);
    localparam logic [C_POS_W-1:0] C_POS_LAST   = C_POS_W'(CUBE_N - 1);
    localparam logic [CNT_W-1:0]   C_DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W+4:0]   C_DWELL_W    = (CNT_W + 5)'(DWELL);

    localparam logic [3:0] C_MODE_OFF    = 4'd0;
    localparam logic [3:0] C_MODE_STREAM = 4'd3;
    localparam logic [3:0] C_MODE_ALL_ON = 4'd5;
    localparam logic [3:0] C_MODE_HOLD   = 4'd6;

    localparam logic [3:0] C_CMD_MODE   = 4'hA;
    localparam logic [3:0] C_CMD_BRIGHT = 4'hB;
    localparam logic [3:0] C_CMD_FRAME  = 4'hC;

    localparam logic [3:0] C_BRIGHT_RST = 4'h8;

    // Scan phase within one layer
    typedef enum logic [0:0] {
        S_LATCH = 1'b0,
        S_DWELL = 1'b1
    } scan_state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Command / frame store
    logic [3:0]         r_pending_mode;
    logic [3:0]         r_brightness;
    logic               r_frame_busy;
    logic               r_frame_ready;
    logic [C_IDX_W-1:0] r_byte_idx;
    logic               r_front;
    logic [CUBE_N-1:0]  r_buf [2][C_CELLS];

    // Scan engine
    scan_state_t        r_state;
    logic [3:0]         r_mode;
    logic [C_POS_W-1:0] r_layer;
    logic [C_POS_W-1:0] r_row;
    logic               r_strobe;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W:0]     r_on_cycles;

    // Registered pins
    logic [CUBE_N-1:0]  r_layers_out;
    logic [CUBE_N-1:0]  r_latches_out;
    logic [CUBE_N-1:0]  r_data_out;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    scan_state_t        w_state;
    logic [3:0]         w_mode;
    logic [C_POS_W-1:0] w_layer;
    logic [C_POS_W-1:0] w_row;
    logic               w_strobe;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W:0]     w_on_cycles;
    logic               w_swap;

    logic [CNT_W:0]     w_on_calc;
    logic [C_IDX_W-1:0] w_rd_idx;
    logic [CUBE_N-1:0]  w_row_data;
    logic [CUBE_N-1:0]  w_row_onehot;
    logic [CUBE_N-1:0]  w_layer_onehot;
    logic [CUBE_N-1:0]  w_layers_nx;
    logic [CUBE_N-1:0]  w_latches_nx;
    logic [CUBE_N-1:0]  w_data_nx;
    logic               w_mode_legal;

    // Lit cycles per dwell: product formed at full width before the /16
    assign w_on_calc = (CNT_W + 1)'(({{(CNT_W + 1){1'b0}}, r_brightness} * C_DWELL_W) >> 4);

    // Front-buffer address of the row currently being latched
    assign w_rd_idx       = C_IDX_W'(int'(r_layer) * CUBE_N + int'(r_row));
    assign w_row_onehot   = {{(CUBE_N - 1){1'b0}}, 1'b1} << r_row;
    assign w_layer_onehot = {{(CUBE_N - 1){1'b0}}, 1'b1} << r_layer;

    // Only OFF, STREAM, ALL_ON and HOLD are accepted as mode codes
    assign w_mode_legal = (uart_in[3:0] == C_MODE_OFF)    ||
                          (uart_in[3:0] == C_MODE_STREAM) ||
                          (uart_in[3:0] == C_MODE_ALL_ON) ||
                          (uart_in[3:0] == C_MODE_HOLD);

    // Scan next-state: walks LATCH rows, then DWELL, advancing layer on the last dwell cycle
    always_comb begin
        w_state     = r_state;
        w_mode      = r_mode;
        w_layer     = r_layer;
        w_row       = r_row;
        w_strobe    = r_strobe;
        w_cnt       = r_cnt;
        w_on_cycles = r_on_cycles;
        w_swap      = 1'b0;

        if (r_mode == C_MODE_OFF) begin
            // Parked at the reset position; leave OFF as soon as a mode is pending
            w_state  = S_LATCH;
            w_layer  = '0;
            w_row    = '0;
            w_strobe = 1'b0;
            w_cnt    = '0;
            if (r_pending_mode != C_MODE_OFF) begin
                w_mode = r_pending_mode;
                w_swap = r_frame_ready && (r_pending_mode != C_MODE_HOLD);
            end
        end else begin
            case (r_state)
                S_LATCH: begin
                    if (!r_strobe) begin
                        w_strobe = 1'b1;
                    end else begin
                        w_strobe = 1'b0;
                        if (r_row == C_POS_LAST) begin
                            // Brightness is sampled once per dwell so a dwell never changes duty midway
                            w_state     = S_DWELL;
                            w_row       = '0;
                            w_cnt       = '0;
                            w_on_cycles = w_on_calc;
                        end else begin
                            w_row = r_row + 1'b1;
                        end
                    end
                end
                S_DWELL: begin
                    if (r_cnt == C_DWELL_LAST) begin
                        // Layer boundary: the only point where a new mode is applied
                        w_mode  = r_pending_mode;
                        w_state = S_LATCH;
                        w_cnt   = '0;
                        if (r_layer == C_POS_LAST) begin
                            w_layer = '0;
                            w_swap  = r_frame_ready && (r_pending_mode != C_MODE_HOLD);
                        end else begin
                            w_layer = r_layer + 1'b1;
                        end
                        if (r_pending_mode == C_MODE_OFF) begin
                            w_layer = '0;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state = S_LATCH;
                end
            endcase
        end
    end

    // Scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LATCH;
            r_mode      <= C_MODE_OFF;
            r_layer     <= '0;
            r_row       <= '0;
            r_strobe    <= 1'b0;
            r_cnt       <= '0;
            r_on_cycles <= '0;
        end else begin
            r_state     <= w_state;
            r_mode      <= w_mode;
            r_layer     <= w_layer;
            r_row       <= w_row;
            r_strobe    <= w_strobe;
            r_cnt       <= w_cnt;
            r_on_cycles <= w_on_cycles;
        end
    end

    // Pin values for the current scan position (layers stay dark during LATCH)
    always_comb begin
        w_layers_nx  = '0;
        w_latches_nx = '0;
        w_data_nx    = '0;
        w_row_data   = (r_mode == C_MODE_ALL_ON) ? {CUBE_N{1'b1}} : r_buf[r_front][w_rd_idx];
        if (r_mode != C_MODE_OFF) begin
            if (r_state == S_LATCH) begin
                w_data_nx = w_row_data;
                if (r_strobe) begin
                    w_latches_nx = w_row_onehot;
                end
            end else if ({1'b0, r_cnt} < r_on_cycles) begin
                w_layers_nx = w_layer_onehot;
            end
        end
    end

    // Output pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_layers_out  <= '0;
            r_latches_out <= '0;
            r_data_out    <= '0;
        end else begin
            r_layers_out  <= w_layers_nx;
            r_latches_out <= w_latches_nx;
            r_data_out    <= w_data_nx;
        end
    end

    // Command decode, frame upload into the back buffer, and buffer swap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending_mode <= C_MODE_OFF;
            r_brightness   <= C_BRIGHT_RST;
            r_frame_busy   <= 1'b0;
            r_frame_ready  <= 1'b0;
            r_byte_idx     <= '0;
            r_front        <= 1'b0;
            for (int i = 0; i < C_CELLS; i++) begin
                r_buf[0][i] <= '0;
                r_buf[1][i] <= '0;
            end
        end else begin
            if (w_swap) begin
                r_front       <= ~r_front;
                r_frame_ready <= 1'b0;
            end
            if (readdatavalid) begin
                if (r_frame_busy) begin
                    // Every byte inside an upload is row data, whatever its value
                    r_buf[~r_front][r_byte_idx] <= uart_in[CUBE_N-1:0];
                    if (r_byte_idx == C_IDX_LAST) begin
                        r_frame_busy  <= 1'b0;
                        r_frame_ready <= 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                    end
                end else begin
                    case (uart_in[7:4])
                        C_CMD_MODE: begin
                            if (w_mode_legal) begin
                                r_pending_mode <= uart_in[3:0];
                            end
                        end
                        C_CMD_BRIGHT: begin
                            r_brightness <= uart_in[3:0];
                        end
                        C_CMD_FRAME: begin
                            // A new header overrides any ready flag, including a same-cycle swap clear
                            r_frame_busy  <= 1'b1;
                            r_byte_idx    <= '0;
                            r_frame_ready <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign layers_out  = r_layers_out;
    assign latches_out = r_latches_out;
    assign data_out    = r_data_out;
    assign mode        = r_mode;
    assign frame_busy  = r_frame_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_cube_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_cube_scan_driver
//  Description : Self-checking bench for led_cube_scan_driver (CUBE_N=4,
//                DWELL=16). A cycle-level behavioural model tracks the
//                position inside each layer as a single counter and holds the
//                frames as plain arrays; every cycle all outputs are compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_cube_scan_driver;

    localparam int N         = 4;
    localparam int DW        = 16;
    localparam int CW        = 8;
    localparam int CELLS     = N * N;
    localparam int LAYER_LEN = 2 * N + DW;
    localparam int MASK      = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   uart_in;
    logic         readdatavalid;
    logic [N-1:0] layers_out;
    logic [N-1:0] latches_out;
    logic [N-1:0] data_out;
    logic [3:0]   mode;
    logic         frame_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode, m_pend, m_bright, m_on;
    int m_busy, m_idx, m_ready;
    int m_layer, m_pos;
    int m_front [CELLS];
    int m_back  [CELLS];
    int e_layers, e_latches, e_data;

    always #5 clk = ~clk;

    led_cube_scan_driver #(
        .CUBE_N (N),
        .DWELL  (DW),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_in       (uart_in),
        .readdatavalid (readdatavalid),
        .layers_out    (layers_out),
        .latches_out   (latches_out),
        .data_out      (data_out),
        .mode          (mode),
        .frame_busy    (frame_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_bright = 8; m_on = 0;
        m_busy = 0; m_idx = 0; m_ready = 0;
        m_layer = 0; m_pos = 0;
        for (int i = 0; i < CELLS; i++) begin
            m_front[i] = 0;
            m_back[i]  = 0;
        end
        e_layers = 0; e_latches = 0; e_data = 0;
    endtask

    // Advance the model by one clock given the inputs seen at that edge
    task automatic model_step(input logic r, input logic v, input logic [7:0] b);
        int p_mode, p_pend, p_ready, row, tmp;
        bit swap;
        if (r) begin
            model_reset();
            return;
        end
        p_mode  = m_mode;
        p_pend  = m_pend;
        p_ready = m_ready;

        // Pins show where the scan was before this edge
        e_layers = 0; e_latches = 0; e_data = 0;
        if (p_mode != 0) begin
            if (m_pos < 2 * N) begin
                row    = m_pos / 2;
                e_data = (p_mode == 5) ? MASK : m_front[m_layer * N + row];
                if (m_pos % 2 == 1) e_latches = 1 << row;
            end else if (m_pos - 2 * N < m_on) begin
                e_layers = 1 << m_layer;
            end
        end

        // Scan position and mode
        swap = 0;
        if (p_mode == 0) begin
            if (p_pend != 0) begin
                m_mode = p_pend;
                swap   = (p_ready != 0) && (p_pend != 6);
            end
        end else if (m_pos == LAYER_LEN - 1) begin
            m_mode  = p_pend;
            m_pos   = 0;
            m_layer = (m_layer + 1) % N;
            swap    = (m_layer == 0) && (p_ready != 0) && (p_pend != 6);
            if (p_pend == 0) m_layer = 0;
        end else begin
            if (m_pos == 2 * N - 1) m_on = (m_bright * DW) >> 4;
            m_pos++;
        end
        if (swap) begin
            for (int i = 0; i < CELLS; i++) begin
                tmp        = m_front[i];
                m_front[i] = m_back[i];
                m_back[i]  = tmp;
            end
            m_ready = 0;
        end

        // Byte stream
        if (v) begin
            if (m_busy != 0) begin
                m_back[m_idx] = int'(b) & MASK;
                if (m_idx == CELLS - 1) begin
                    m_busy  = 0;
                    m_ready = 1;
                end else begin
                    m_idx++;
                end
            end else begin
                case (b[7:4])
                    4'hA: if (int'(b[3:0]) inside {0, 3, 5, 6}) m_pend = int'(b[3:0]);
                    4'hB: m_bright = int'(b[3:0]);
                    4'hC: begin m_busy = 1; m_idx = 0; m_ready = 0; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] b);
        rst           = r;
        readdatavalid = v;
        uart_in       = b;
        @(posedge clk);
        model_step(r, v, b);
        #1;
        check("layers_out",  32'(layers_out),  e_layers);
        check("latches_out", 32'(latches_out), e_latches);
        check("data_out",    32'(data_out),    e_data);
        check("mode",        32'(mode),        m_mode);
        check("frame_busy",  32'(frame_busy),  m_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b0, 1'b1, b);
    endtask

    task automatic send_gappy(input logic [7:0] b);
        idle($urandom_range(0, 2));
        send(b);
    endtask

    initial begin
        logic [7:0] rb;
        int         k;
        int         guard;

        rst = 1'b1; readdatavalid = 1'b0; uart_in = 8'h00;
        model_reset();

        // 1: reset held three cycles, then OFF with no traffic
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
        idle(40);

        // 2: ALL_ON at default brightness across more than a full frame
        send(8'hA5);
        idle(4 * LAYER_LEN + 10);

        // 3: STREAM, upload 0x01..0x10 and let it swap in
        send(8'hA3);
        send(8'hC0);
        for (int i = 1; i <= CELLS; i++) send_gappy(8'(i));
        idle(3 * 4 * LAYER_LEN);

        // 4: HOLD keeps the shown frame; returning to STREAM swaps
        send(8'hA6);
        idle(LAYER_LEN);
        send(8'hC0);
        for (int i = 0; i < CELLS; i++) send_gappy(8'h0F);
        idle(2 * 4 * LAYER_LEN);
        send(8'hA3);
        idle(2 * 4 * LAYER_LEN);

        // 5: mode change requested mid-dwell of layer 1, illegal code, zero brightness
        guard = 0;
        while (!(m_layer == 1 && m_pos >= 2 * N + 3) && guard < 200) begin
            idle(1);
            guard++;
        end
        check("reach_layer1_dwell", 32'(guard < 200), 32'd1);
        send(8'hA5);
        idle(LAYER_LEN);
        send(8'hA7);
        idle(LAYER_LEN);
        send(8'hB0);
        idle(2 * 4 * LAYER_LEN);
        send(8'hBF);
        idle(4 * LAYER_LEN);

        // 6: reset during an upload; next byte is a command again
        send(8'hC0);
        for (int i = 0; i < 5; i++) send(8'(8'h20 + i));
        cycle(1'b1, 1'b0, 8'h00);
        send(8'hA3);
        idle(4 * LAYER_LEN);

        // 7: randomized traffic: commands, uploads, illegal codes, occasional reset
        for (int i = 0; i < 2500; i++) begin
            k = $urandom_range(0, 99);
            if (k == 0) begin
                cycle(1'b1, 1'b0, 8'h00);
            end else if (k < 60) begin
                idle(1);
            end else begin
                case ($urandom_range(0, 4))
                    0: rb = {4'hA, 4'($urandom_range(0, 15))};
                    1: rb = {4'hB, 4'($urandom_range(0, 15))};
                    2: rb = {4'hC, 4'($urandom_range(0, 15))};
                    3: rb = {4'hA, 4'($urandom_range(0, 1) ? 4'h3 : 4'h5)};
                    default: rb = 8'($urandom_range(0, 255));
                endcase
                send(rb);
            end
        end
        idle(2 * 4 * LAYER_LEN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
